// File: rtl/fifo_rd_drain.sv
// Read-side drain stage: pops the async FIFO and feeds a 2-entry skid buffer
// that presents words to the consumer on a valid/ready handshake.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst,
    input  logic                  i_enable,
    input  logic                  i_rempty,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_rinc,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_idle,
    output logic [CNT_WIDTH-1:0]  o_rd_cnt
);

    logic [1:0]            r_occ;
    logic                  r_land;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_inflight;
    logic [2:0]            w_load;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_xfer;
    logic [1:0]            w_occ_rem;
    logic [1:0]            w_occ_nxt;

    // Landing words are counted against the buffer so a pop always has a slot.
    assign w_inflight = (RD_LAT != 0) ? r_land : 1'b0;
    assign w_load     = {1'b0, r_occ} + {2'b00, w_inflight};
    assign w_pop      = i_enable & ~i_rempty & (w_load < 3'd2) & ~i_rrst;
    assign w_wr       = (RD_LAT != 0) ? r_land : w_pop;
    assign w_xfer     = r_valid & i_ready;
    assign w_occ_rem  = r_occ - {1'b0, w_xfer};
    assign w_occ_nxt  = w_occ_rem + {1'b0, w_wr};

    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            r_occ   <= 2'd0;
            r_land  <= 1'b0;
            r_valid <= 1'b0;
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_cnt   <= '0;
        end else begin
            r_land  <= w_pop;
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != 2'd0);
            if (w_xfer) begin
                r_buf0 <= r_buf1;
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end
            // New word goes behind whatever remains after this edge's transfer.
            if (w_wr) begin
                if (w_occ_rem == 2'd0)
                    r_buf0 <= i_rdata;
                else
                    r_buf1 <= i_rdata;
            end
        end
    end

    assign o_rinc   = w_pop;
    assign o_data   = r_buf0;
    assign o_valid  = r_valid;
    assign o_idle   = (r_occ == 2'd0) & ~w_inflight;
    assign o_rd_cnt = r_cnt;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: one instance with RD_LAT=0 and a 4-bit
// counter, one with RD_LAT=1, each fed by a small FIFO read-side model.
module tb_fifo_rd_drain;

    logic       clk = 1'b0;
    int         errors = 0;
    int         checks = 0;

    logic       rstA, enA, rdyA;
    logic       rincA, validA, idleA, emptyA;
    logic [7:0] rdataA, dataA;
    logic [3:0] cntA;

    logic       rstB, enB, rdyB;
    logic       rincB, validB, idleB, emptyB;
    logic [7:0] rdataB, dataB;
    logic [15:0] cntB;

    logic [7:0] memA [128];
    logic [7:0] memB [128];
    logic [6:0] wptrA = '0, rptrA = '0;
    logic [6:0] wptrB = '0, rptrB = '0;
    logic [7:0] qa [$];
    logic [7:0] qb [$];

    always #5 clk = ~clk;

    fifo_rd_drain #(.DATA_WIDTH(8), .RD_LAT(0), .CNT_WIDTH(4)) u_a (
        .i_rclk(clk), .i_rrst(rstA), .i_enable(enA), .i_rempty(emptyA),
        .i_rdata(rdataA), .o_rinc(rincA), .o_data(dataA), .o_valid(validA),
        .i_ready(rdyA), .o_idle(idleA), .o_rd_cnt(cntA)
    );

    fifo_rd_drain #(.DATA_WIDTH(8), .RD_LAT(1), .CNT_WIDTH(16)) u_b (
        .i_rclk(clk), .i_rrst(rstB), .i_enable(enB), .i_rempty(emptyB),
        .i_rdata(rdataB), .o_rinc(rincB), .o_data(dataB), .o_valid(validB),
        .i_ready(rdyB), .o_idle(idleB), .o_rd_cnt(cntB)
    );

    // FIFO read side: A has combinational read data, B one cycle of latency.
    assign emptyA = (rptrA == wptrA);
    assign emptyB = (rptrB == wptrB);
    assign rdataA = memA[rptrA];

    always @(posedge clk) begin
        if (rincA) rptrA <= rptrA + 7'd1;
        if (rincB) rptrB <= rptrB + 7'd1;
        rdataB <= memB[rptrB];
    end

    // Order scoreboard: popped words must come out in pop order.
    always @(negedge clk) begin
        if (rstA) begin
            qa.delete();
        end else begin
            if (validA && rdyA) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $error("FAIL underflow_a: got %0h expected none", dataA);
                end else begin
                    assert (dataA === qa[0]) else begin
                        errors++;
                        $error("FAIL order_a: got %0h expected %0h", dataA, qa[0]);
                    end
                    void'(qa.pop_front());
                end
            end
            if (rincA) qa.push_back(memA[rptrA]);
        end
        if (rstB) begin
            qb.delete();
        end else begin
            if (validB && rdyB) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $error("FAIL underflow_b: got %0h expected none", dataB);
                end else begin
                    assert (dataB === qb[0]) else begin
                        errors++;
                        $error("FAIL order_b: got %0h expected %0h", dataB, qb[0]);
                    end
                    void'(qb.pop_front());
                end
            end
            if (rincB) qb.push_back(memB[rptrB]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushA(input logic [7:0] v);
        memA[wptrA] = v;
        wptrA = wptrA + 7'd1;
    endtask

    task automatic pushB(input logic [7:0] v);
        memB[wptrB] = v;
        wptrB = wptrB + 7'd1;
    endtask

    task automatic drainA(input string tag, input int maxc);
        int n = 0;
        while (!(idleA && emptyA) && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < maxc), 32'd1);
    endtask

    task automatic drainB(input string tag, input int maxc, input bit toggle);
        int n = 0;
        while (!(idleB && emptyB) && n < maxc) begin
            if (toggle) rdyB = ~rdyB;
            tick();
            n++;
        end
        chk(tag, 32'(n < maxc), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            memA[i] = '0;
            memB[i] = '0;
        end
        rstA = 1; rstB = 1;
        enA = 1; enB = 0;
        rdyA = 1; rdyB = 1;
        for (int i = 0; i < 8; i++) pushA(8'(8'h11 + i));

        tick();
        tick();
        chk("reset_valid", 32'(validA), 32'd0);
        chk("reset_cnt", 32'(cntA), 32'd0);
        chk("reset_idle", 32'(idleA), 32'd1);
        chk("reset_rinc", 32'(rincA), 32'd0);
        chk("reset_valid_b", 32'(validB), 32'd0);

        rstA = 0; rstB = 0;
        #1;
        chk("stream_first_rinc", 32'(rincA), 32'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("stream_data", 32'(dataA), 32'(8'h11 + k));
            chk("stream_valid", 32'(validA), 32'd1);
            chk("stream_cnt", 32'(cntA), 32'(k));
            chk("stream_rinc", 32'(rincA), 32'(k < 7));
        end
        tick();
        chk("stream_end_valid", 32'(validA), 32'd0);
        chk("stream_end_cnt", 32'(cntA), 32'd8);
        chk("stream_end_idle", 32'(idleA), 32'd1);

        for (int i = 0; i < 10; i++) pushA(8'(8'h21 + i));
        tick();
        tick();
        chk("bp_head", 32'(dataA), 32'h22);
        rdyA = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_data", 32'(dataA), 32'h22);
            chk("bp_hold_valid", 32'(validA), 32'd1);
            chk("bp_hold_rinc", 32'(rincA), 32'd0);
        end
        rdyA = 1;
        tick();
        chk("bp_release", 32'(dataA), 32'h23);
        drainA("bp_drain", 40);
        chk("bp_cnt", 32'(cntA), 32'd2);
        chk("bp_lost", 32'(qa.size()), 32'd0);

        rdyA = 0;
        for (int i = 0; i < 6; i++) pushA(8'(8'h31 + i));
        tick();
        tick();
        chk("rs_full_rinc", 32'(rincA), 32'd0);
        chk("rs_full_data", 32'(dataA), 32'h31);
        rstA = 1;
        tick();
        chk("rs_valid", 32'(validA), 32'd0);
        chk("rs_cnt", 32'(cntA), 32'd0);
        chk("rs_idle", 32'(idleA), 32'd1);
        rstA = 0;
        rdyA = 1;
        tick();
        chk("rs_resume", 32'(dataA), 32'h33);
        drainA("rs_drain", 40);
        chk("rs_after_cnt", 32'(cntA), 32'd4);

        rstA = 1;
        tick();
        rstA = 0;
        for (int i = 0; i < 17; i++) pushA(8'(8'h41 + i));
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("wrap_cnt", 32'(cntA), 32'(k % 16));
        end
        tick();
        chk("wrap_final", 32'(cntA), 32'd1);
        chk("wrap_idle", 32'(idleA), 32'd1);

        for (int i = 0; i < 8; i++) pushB(8'(8'h51 + i));
        enB = 1;
        #1;
        chk("b_first_rinc", 32'(rincB), 32'd1);
        tick();
        chk("b_f1_valid", 32'(validB), 32'd0);
        chk("b_f1_rinc", 32'(rincB), 32'd1);
        chk("b_f1_idle", 32'(idleB), 32'd0);
        tick();
        chk("b_f2_valid", 32'(validB), 32'd1);
        chk("b_f2_data", 32'(dataB), 32'h51);
        chk("b_f2_rinc", 32'(rincB), 32'd0);
        drainB("b_toggle_drain", 80, 1'b1);
        chk("b_toggle_cnt", 32'(cntB), 32'd8);
        chk("b_toggle_lost", 32'(qb.size()), 32'd0);

        enB = 0;
        rdyB = 1;
        for (int i = 0; i < 4; i++) pushB(8'(8'h61 + i));
        enB = 1;
        tick();
        chk("b_g1_idle", 32'(idleB), 32'd0);
        enB = 0;
        #1;
        chk("b_g1_rinc", 32'(rincB), 32'd0);
        tick();
        chk("b_g2_valid", 32'(validB), 32'd1);
        chk("b_g2_data", 32'(dataB), 32'h61);
        chk("b_g2_rinc", 32'(rincB), 32'd0);
        tick();
        chk("b_g3_valid", 32'(validB), 32'd0);
        chk("b_g3_idle", 32'(idleB), 32'd1);
        chk("b_g3_cnt", 32'(cntB), 32'd9);
        tick();
        tick();
        chk("b_off_idle", 32'(idleB), 32'd1);
        chk("b_off_cnt", 32'(cntB), 32'd9);
        enB = 1;
        #1;
        chk("b_re_rinc", 32'(rincB), 32'd1);
        tick();
        tick();
        chk("b_re_valid", 32'(validB), 32'd1);
        chk("b_re_data", 32'(dataB), 32'h62);
        drainB("b_re_drain", 40, 1'b0);
        chk("b_re_cnt", 32'(cntB), 32'd12);
        chk("b_re_lost", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
